// File: rtl/addr_dec_resp_fifo.sv
// Address decoder and in-order response mux for one master port of the TCDM
// crossbar. Requests are steered to the slave selected by add_i; the target
// index of every request that expects a response is queued in a small FIFO so
// responses can be returned to the master in issue order, even when slaves
// answer out of order or with variable latency.
//
// Optional build macro: ADDR_DEC_RESP_FIFO_OUT_REG_EN
//   Defined   -> a response output register sits between the mux and the
//                master (+1 cycle response latency, full throughput).
//   Undefined -> the response path is purely combinational.
module addr_dec_resp_fifo #(
  parameter int unsigned NumOut         = 8,
  parameter int unsigned ReqDataWidth   = 32,
  parameter int unsigned RespDataWidth  = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned WriteRespOn    = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  // master side
  input  logic                               req_i,
  input  logic [$clog2(NumOut)-1:0]          add_i,
  input  logic                               wen_i,
  input  logic [ReqDataWidth-1:0]            data_i,
  output logic                               gnt_o,
  output logic                               vld_o,
  output logic [RespDataWidth-1:0]           rdata_o,
  input  logic                               rdy_i,
  // slave side
  output logic [NumOut-1:0]                  req_o,
  input  logic [NumOut-1:0]                  gnt_i,
  output logic [NumOut*ReqDataWidth-1:0]     data_o,
  input  logic [NumOut-1:0]                  rvld_i,
  input  logic [NumOut*RespDataWidth-1:0]    rdata_i,
  output logic [NumOut-1:0]                  rrdy_o,
  // status
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                               idle_o
);

  localparam int unsigned IdxW = $clog2(NumOut);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  localparam logic            WrRsp   = (WriteRespOn != 0);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];

  logic                     full;
  logic                     nonempty;
  logic                     push;
  logic                     pop;
  logic [CntW-1:0]          occ;
  logic [IdxW-1:0]          head_idx;
  logic [NumOut-1:0]        head_sel;
  logic                     head_vld;
  logic [RespDataWidth-1:0] head_data;

  assign full     = (occ == MaxCnt);
  assign nonempty = (count_q != '0);
  assign head_idx = fifo_q[rd_ptr_q];
  assign data_o   = {NumOut{data_i}};
  assign push     = gnt_o & (~wen_i | WrRsp);

  // Request decode: only the addressed port sees the request, and only while
  // there is room to remember where its response must come from.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    req_o = '0;
    gnt_o = 1'b0;
    for (int unsigned s = 0; s < NumOut; s++) begin
      if (add_i == IdxW'(s)) begin
        req_o[s] = req_i & ~full & rst_ni;
        gnt_o    = gnt_i[s] & req_o[s];
      end
    end
  end

  // Head-of-queue select: which slave's response is next in issue order.
  always_comb begin
    head_sel  = '0;
    head_vld  = 1'b0;
    head_data = '0;
    for (int unsigned s = 0; s < NumOut; s++) begin
      if (head_idx == IdxW'(s)) begin
        head_sel[s] = 1'b1;
        head_vld    = rvld_i[s];
        head_data   = rdata_i[s*RespDataWidth +: RespDataWidth];
      end
    end
  end

`ifdef ADDR_DEC_RESP_FIFO_OUT_REG_EN
  logic                     out_vld_q, out_vld_d;
  logic [RespDataWidth-1:0] out_data_q, out_data_d;
  logic                     take;

  // The register can accept a new response when empty or being drained.
  assign take    = ~out_vld_q | rdy_i;
  assign pop     = head_vld & nonempty & take;
  assign rrdy_o  = head_sel & {NumOut{take & nonempty}};
  assign vld_o   = out_vld_q;
  assign rdata_o = out_data_q;
  assign occ     = count_q + CntW'(out_vld_q);

  // Output register next state: load on a slave-side pop, clear on drain.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    if (pop) begin
      out_vld_d  = 1'b1;
      out_data_d = head_data;
    end else if (rdy_i) begin
      out_vld_d  = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end
`else
  // Combinational response path: present the head response the same cycle.
  assign vld_o   = head_vld & nonempty;
  assign rdata_o = nonempty ? head_data : '0;
  assign rrdy_o  = head_sel & {NumOut{rdy_i & nonempty}};
  assign pop     = vld_o & rdy_i;
  assign occ     = count_q;
`endif

  assign outstanding_o = occ;
  assign idle_o        = (occ == '0);

  // Pointer and occupancy next state; pointers wrap at MaxOutstanding-1.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
  end

  // FIFO control state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage of target indices.
  // NOTE: the storage array is deliberately not reset; entries are only read
  // when count_q says they were written, and the pointers are reset.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= add_i;
  end

`ifndef SYNTHESIS
  if (NumOut < 2) begin : g_bad_numout
    $fatal(1, "addr_dec_resp_fifo: NumOut must be >= 2");
  end
  if (MaxOutstanding < 1) begin : g_bad_maxout
    $fatal(1, "addr_dec_resp_fifo: MaxOutstanding must be >= 1");
  end

  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && count_q == '0))
    else $error("addr_dec_resp_fifo: pop while empty");

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && count_q == MaxCnt))
    else $error("addr_dec_resp_fifo: push while full");

  a_rdata_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (vld_o && !rdy_i) |=> (!vld_o || $stable(rdata_o)))
    else $error("addr_dec_resp_fifo: rdata_o changed while stalled");
`endif

endmodule

// File: tb/tb_addr_dec_resp_fifo.sv
// Self-checking bench for addr_dec_resp_fifo: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_addr_dec_resp_fifo;

  localparam int NO = 8;
  localparam int DW = 32;
  localparam int RW = 32;
  localparam int MO = 4;
  localparam int IW = 3;
  localparam int CW = 3;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              req_i;
  logic [IW-1:0]     add_i;
  logic              wen_i;
  logic [DW-1:0]     data_i;
  logic              rdy_i;
  logic [NO-1:0]     gnt_i;
  logic [NO-1:0]     rvld_i;
  logic [NO*RW-1:0]  rdata_i;

  logic              gnt_o, vld_o, idle_o;
  logic [RW-1:0]     rdata_o;
  logic [NO-1:0]     req_o, rrdy_o;
  logic [NO*DW-1:0]  data_o;
  logic [CW-1:0]     outstanding_o;

  logic              gnt_o_w, vld_o_w, idle_o_w;
  logic [RW-1:0]     rdata_o_w;
  logic [NO-1:0]     req_o_w, rrdy_o_w;
  logic [NO*DW-1:0]  data_o_w;
  logic [CW-1:0]     outstanding_o_w;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  addr_dec_resp_fifo #(
    .NumOut(NO), .ReqDataWidth(DW), .RespDataWidth(RW),
    .MaxOutstanding(MO), .WriteRespOn(1)
  ) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i),
    .wen_i(wen_i), .data_i(data_i), .gnt_o(gnt_o), .vld_o(vld_o),
    .rdata_o(rdata_o), .rdy_i(rdy_i), .req_o(req_o), .gnt_i(gnt_i),
    .data_o(data_o), .rvld_i(rvld_i), .rdata_i(rdata_i), .rrdy_o(rrdy_o),
    .outstanding_o(outstanding_o), .idle_o(idle_o)
  );

  addr_dec_resp_fifo #(
    .NumOut(NO), .ReqDataWidth(DW), .RespDataWidth(RW),
    .MaxOutstanding(MO), .WriteRespOn(0)
  ) u_dut_w (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i),
    .wen_i(wen_i), .data_i(data_i), .gnt_o(gnt_o_w), .vld_o(vld_o_w),
    .rdata_o(rdata_o_w), .rdy_i(rdy_i), .req_o(req_o_w), .gnt_i(gnt_i),
    .data_o(data_o_w), .rvld_i(rvld_i), .rdata_i(rdata_i), .rrdy_o(rrdy_o_w),
    .outstanding_o(outstanding_o_w), .idle_o(idle_o_w)
  );

  task automatic idle_inputs();
    req_i = 1'b0; add_i = '0; wen_i = 1'b0; data_i = '0; rdy_i = 1'b0;
    gnt_i = '0; rvld_i = '0; rdata_i = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic set_resp(input int s, input logic [RW-1:0] d);
    rvld_i[s] = 1'b1;
    rdata_i[s*RW +: RW] = d;
  endtask

  task automatic send_read(input int s);
    idle_inputs();
    req_i = 1'b1; add_i = IW'(s); gnt_i = '1; rdy_i = 1'b1; data_i = $urandom;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0; req_i = 1'b1; add_i = 3'd2; gnt_i = '1; rvld_i = '1;
    rdata_i = '1; rdy_i = 1'b1;
    #1;
    tests_run++; if (req_o !== '0) begin tests_failed++; $display("FAIL rst_req: got %h want 00", req_o); end
    tests_run++; if (gnt_o !== 1'b0) begin tests_failed++; $display("FAIL rst_gnt: got %b want 0", gnt_o); end
    tests_run++; if (vld_o !== 1'b0) begin tests_failed++; $display("FAIL rst_vld: got %b want 0", vld_o); end
    tests_run++; if (rrdy_o !== '0) begin tests_failed++; $display("FAIL rst_rrdy: got %h want 00", rrdy_o); end
    tests_run++; if (rdata_o !== '0) begin tests_failed++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
    tests_run++; if (outstanding_o !== '0) begin tests_failed++; $display("FAIL rst_out: got %0d want 0", outstanding_o); end
    tests_run++; if (idle_o !== 1'b1) begin tests_failed++; $display("FAIL rst_idle: got %b want 1", idle_o); end
    @(negedge clk_i);
    idle_inputs();
    rst_ni = 1'b1;
  endtask

  task automatic test_fixed_latency();
    int          tgt[4]     = '{3, 5, 3, 0};
    logic [31:0] dat[4]     = '{32'h3333_0001, 32'h5555_0002, 32'h3333_0003, 32'h0000_0004};
    int          exp_out[6] = '{0, 1, 2, 2, 2, 1};
    int          peak       = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      rdy_i = 1'b1; gnt_i = '1;
      if (c < 4) begin req_i = 1'b1; add_i = IW'(tgt[c]); data_i = $urandom; end
      if (c >= 2) set_resp(tgt[c-2], dat[c-2]);
      #1;
      if (int'(outstanding_o) > peak) peak = int'(outstanding_o);
      tests_run++; if (outstanding_o !== CW'(exp_out[c])) begin tests_failed++; $display("FAIL fl_out c%0d: got %0d want %0d", c, outstanding_o, exp_out[c]); end
      tests_run++; if (vld_o !== (c >= 2)) begin tests_failed++; $display("FAIL fl_vld c%0d: got %b want %b", c, vld_o, (c >= 2)); end
      if (c >= 2) begin
        tests_run++; if (rdata_o !== dat[c-2]) begin tests_failed++; $display("FAIL fl_rdata c%0d: got %h want %h", c, rdata_o, dat[c-2]); end
      end
      if (c < 4) begin
        tests_run++; if (gnt_o !== 1'b1) begin tests_failed++; $display("FAIL fl_gnt c%0d: got %b want 1", c, gnt_o); end
      end
      tick();
    end
    idle_inputs();
    #1;
    tests_run++; if (peak != 2) begin tests_failed++; $display("FAIL fl_peak: got %0d want 2", peak); end
    tests_run++; if (idle_o !== 1'b1) begin tests_failed++; $display("FAIL fl_idle: got %b want 1", idle_o); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    send_read(1); tick();
    send_read(2); tick();
    for (int c = 0; c < 2; c++) begin
      idle_inputs(); rdy_i = 1'b1; set_resp(2, 32'h0000_BEEF);
      #1;
      tests_run++; if (vld_o !== 1'b0) begin tests_failed++; $display("FAIL ooo_stall_vld c%0d: got %b want 0", c, vld_o); end
      tests_run++; if (rrdy_o !== 8'h02) begin tests_failed++; $display("FAIL ooo_stall_rrdy c%0d: got %h want 02", c, rrdy_o); end
      tick();
    end
    idle_inputs(); rdy_i = 1'b1;
    set_resp(1, 32'h0000_A5A5); set_resp(2, 32'h0000_BEEF);
    #1;
    tests_run++; if (vld_o !== 1'b1 || rdata_o !== 32'h0000_A5A5) begin tests_failed++; $display("FAIL ooo_first: got vld=%b %h want 1 0000a5a5", vld_o, rdata_o); end
    tests_run++; if (rrdy_o !== 8'h02) begin tests_failed++; $display("FAIL ooo_first_rrdy: got %h want 02", rrdy_o); end
    tick();
    idle_inputs(); rdy_i = 1'b1; set_resp(2, 32'h0000_BEEF);
    #1;
    tests_run++; if (vld_o !== 1'b1 || rdata_o !== 32'h0000_BEEF) begin tests_failed++; $display("FAIL ooo_second: got vld=%b %h want 1 0000beef", vld_o, rdata_o); end
    tests_run++; if (rrdy_o !== 8'h04) begin tests_failed++; $display("FAIL ooo_second_rrdy: got %h want 04", rrdy_o); end
    tick();
    idle_inputs();
    #1;
    tests_run++; if (outstanding_o !== '0) begin tests_failed++; $display("FAIL ooo_drained: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_full_stall();
    int heads[4] = '{1, 2, 3, 6};
    do_reset();
    for (int s = 0; s < 4; s++) begin send_read(s); tick(); end
    send_read(6);
    #1;
    tests_run++; if (req_o !== '0 || gnt_o !== 1'b0) begin tests_failed++; $display("FAIL full_block: got req=%h gnt=%b want 00 0", req_o, gnt_o); end
    tests_run++; if (outstanding_o !== 3'd4) begin tests_failed++; $display("FAIL full_out: got %0d want 4", outstanding_o); end
    tick();
    send_read(6); set_resp(0, 32'h0000_00F0);
    #1;
    tests_run++; if (req_o !== '0 || gnt_o !== 1'b0) begin tests_failed++; $display("FAIL full_pop_block: got req=%h gnt=%b want 00 0", req_o, gnt_o); end
    tests_run++; if (vld_o !== 1'b1 || rdata_o !== 32'h0000_00F0) begin tests_failed++; $display("FAIL full_pop: got vld=%b %h want 1 000000f0", vld_o, rdata_o); end
    tick();
    send_read(6);
    #1;
    tests_run++; if (req_o !== 8'h40 || gnt_o !== 1'b1) begin tests_failed++; $display("FAIL full_resume: got req=%h gnt=%b want 40 1", req_o, gnt_o); end
    tests_run++; if (outstanding_o !== 3'd3) begin tests_failed++; $display("FAIL full_resume_out: got %0d want 3", outstanding_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); rdy_i = 1'b1; set_resp(heads[i], 32'h0000_0F00 + heads[i]);
      #1;
      tests_run++; if (vld_o !== 1'b1 || rdata_o !== 32'h0000_0F00 + heads[i]) begin tests_failed++; $display("FAIL full_drain%0d: got vld=%b %h want 1 %h", i, vld_o, rdata_o, 32'h0000_0F00 + heads[i]); end
      tick();
    end
    idle_inputs();
    #1;
    tests_run++; if (outstanding_o !== '0) begin tests_failed++; $display("FAIL full_drained: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    send_read(4); tick();
    for (int c = 0; c < 3; c++) begin
      idle_inputs(); rdy_i = 1'b0; set_resp(4, 32'h0000_1234);
      #1;
      tests_run++; if (vld_o !== 1'b1 || rdata_o !== 32'h0000_1234) begin tests_failed++; $display("FAIL bp_hold c%0d: got vld=%b %h want 1 00001234", c, vld_o, rdata_o); end
      tests_run++; if (rrdy_o !== '0 || outstanding_o !== 3'd1) begin tests_failed++; $display("FAIL bp_nopop c%0d: got rrdy=%h out=%0d want 00 1", c, rrdy_o, outstanding_o); end
      tick();
    end
    idle_inputs(); rdy_i = 1'b1; set_resp(4, 32'h0000_1234);
    #1;
    tests_run++; if (vld_o !== 1'b1 || rrdy_o !== 8'h10) begin tests_failed++; $display("FAIL bp_release: got vld=%b rrdy=%h want 1 10", vld_o, rrdy_o); end
    tick();
    idle_inputs();
    #1;
    tests_run++; if (outstanding_o !== '0) begin tests_failed++; $display("FAIL bp_popped: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_writes_no_resp();
    int tgt[3] = '{2, 7, 2};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_read(tgt[i]); wen_i = 1'b1;
      #1;
      tests_run++; if (gnt_o_w !== 1'b1) begin tests_failed++; $display("FAIL wr_gnt%0d: got %b want 1", i, gnt_o_w); end
      tests_run++; if (outstanding_o_w !== '0 || idle_o_w !== 1'b1) begin tests_failed++; $display("FAIL wr_nocount%0d: got out=%0d idle=%b want 0 1", i, outstanding_o_w, idle_o_w); end
      tick();
    end
    idle_inputs();
    #1;
    tests_run++; if (outstanding_o_w !== '0 || idle_o_w !== 1'b1) begin tests_failed++; $display("FAIL wr_after: got out=%0d idle=%b want 0 1", outstanding_o_w, idle_o_w); end
    tests_run++; if (outstanding_o !== 3'd3) begin tests_failed++; $display("FAIL wr_resp_on: got %0d want 3", outstanding_o); end
    send_read(5); tick();
    idle_inputs();
    #1;
    tests_run++; if (outstanding_o_w !== 3'd1 || idle_o_w !== 1'b0) begin tests_failed++; $display("FAIL wr_rd_count: got out=%0d idle=%b want 1 0", outstanding_o_w, idle_o_w); end
    rdy_i = 1'b1; set_resp(5, 32'h5A5A_0005);
    #1;
    tests_run++; if (vld_o_w !== 1'b1 || rdata_o_w !== 32'h5A5A_0005) begin tests_failed++; $display("FAIL wr_rd_resp: got vld=%b %h want 1 5a5a0005", vld_o_w, rdata_o_w); end
    tick();
    idle_inputs();
    #1;
    tests_run++; if (outstanding_o_w !== '0 || idle_o_w !== 1'b1) begin tests_failed++; $display("FAIL wr_rd_done: got out=%0d idle=%b want 0 1", outstanding_o_w, idle_o_w); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int s = 1; s < 4; s++) begin send_read(s); tick(); end
    send_read(4); set_resp(1, 32'h0000_1111);
    #1;
    tests_run++; if (outstanding_o !== 3'd3) begin tests_failed++; $display("FAIL rm_pre: got %0d want 3", outstanding_o); end
    rst_ni = 1'b0;
    #1;
    tests_run++; if (outstanding_o !== '0 || idle_o !== 1'b1) begin tests_failed++; $display("FAIL rm_count: got out=%0d idle=%b want 0 1", outstanding_o, idle_o); end
    tests_run++; if (vld_o !== 1'b0 || req_o !== '0 || gnt_o !== 1'b0) begin tests_failed++; $display("FAIL rm_outs: got vld=%b req=%h gnt=%b want 0 00 0", vld_o, req_o, gnt_o); end
    @(negedge clk_i);
    idle_inputs();
    rst_ni = 1'b1;
  endtask

  task automatic test_random(input int n);
    int               q[$];
    bit               hold[NO];
    logic [RW-1:0]    hd[NO];
    int               pend[NO];
    logic [NO-1:0]    one = 1;
    logic [NO-1:0]    exp_req, exp_rrdy;
    logic             exp_gnt, exp_vld;
    logic [RW-1:0]    exp_rd;
    int               h;
    do_reset();
    for (int s = 0; s < NO; s++) begin hold[s] = 1'b0; pend[s] = 0; hd[s] = '0; end
    for (int c = 0; c < n; c++) begin
      req_i  = ($urandom_range(0, 3) != 0);
      add_i  = IW'($urandom);
      wen_i  = 1'($urandom);
      data_i = $urandom;
      gnt_i  = NO'($urandom);
      rdy_i  = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NO; s++) begin
        if (!hold[s] && pend[s] > 0 && $urandom_range(0, 1) == 1) begin
          hold[s] = 1'b1;
          hd[s]   = $urandom;
        end
        rvld_i[s] = hold[s];
        rdata_i[s*RW +: RW] = hold[s] ? hd[s] : RW'($urandom);
      end
      #1;
      exp_req  = (req_i && q.size() < MO) ? (one << add_i) : '0;
      exp_gnt  = req_i && q.size() < MO && gnt_i[add_i];
      exp_vld  = 1'b0; exp_rd = '0; exp_rrdy = '0; h = 0;
      if (q.size() > 0) begin
        h        = q[0];
        exp_vld  = rvld_i[h];
        exp_rd   = rdata_i[h*RW +: RW];
        exp_rrdy = rdy_i ? (one << h) : '0;
      end
      tests_run++; if (req_o !== exp_req) begin tests_failed++; $display("FAIL rnd_req c%0d: got %h want %h", c, req_o, exp_req); end
      tests_run++; if (gnt_o !== exp_gnt) begin tests_failed++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt_o, exp_gnt); end
      tests_run++; if (vld_o !== exp_vld) begin tests_failed++; $display("FAIL rnd_vld c%0d: got %b want %b", c, vld_o, exp_vld); end
      tests_run++; if (rdata_o !== exp_rd) begin tests_failed++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, rdata_o, exp_rd); end
      tests_run++; if (rrdy_o !== exp_rrdy) begin tests_failed++; $display("FAIL rnd_rrdy c%0d: got %h want %h", c, rrdy_o, exp_rrdy); end
      tests_run++; if (outstanding_o !== CW'(q.size()) || idle_o !== (q.size() == 0)) begin tests_failed++; $display("FAIL rnd_occ c%0d: got out=%0d idle=%b want %0d %b", c, outstanding_o, idle_o, q.size(), (q.size() == 0)); end
      tests_run++; if (data_o !== {NO{data_i}}) begin tests_failed++; $display("FAIL rnd_data c%0d: got %h want %h", c, data_o, {NO{data_i}}); end
      @(posedge clk_i);
      if (exp_vld && rdy_i) begin
        void'(q.pop_front());
        hold[h] = 1'b0;
        pend[h]--;
      end
      if (exp_gnt) begin
        q.push_back(int'(add_i));
        pend[add_i]++;
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_latency();
    test_out_of_order();
    test_full_stall();
    test_backpressure();
    test_writes_no_resp();
    test_reset_mid();
    test_random(400);
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/addr_dec_resp_fifo.md
Name: addr_dec_resp_fifo

Overview:
- Next-generation address decoder and response mux for one master port of the TCDM crossbar.
- Slaves may answer with variable latency, using a valid/ready response handshake.
- Up to MaxOutstanding transactions can be in flight at once.
- An in-order FIFO of target indices routes each response back to the master. The master can apply back-pressure on responses.

Parameters:
- NumOut, 8: number of slave ports; must be >= 2.
- ReqDataWidth, 32: request payload width.
- RespDataWidth, 32: response payload width.
- MaxOutstanding, 4: depth of the outstanding-transaction FIFO; must be >= 1; need not be a power of two.
- WriteRespOn, 1: 1 means writes return a response; 0 means writes are fire-and-forget.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  master request
- add_i  in  $clog2(NumOut)  target slave index
- wen_i  in  1  write enable
- data_i  in  ReqDataWidth  request payload
- gnt_o  out  1  grant to master
- vld_o  out  1  response valid to master
- rdata_o  out  RespDataWidth  response data to master
- rdy_i  in  1  master ready for a response
- req_o  out  NumOut  decoded request per slave
- gnt_i  in  NumOut  grant per slave
- data_o  out  NumOut x ReqDataWidth  payload broadcast to all slaves
- rvld_i  in  NumOut  response valid per slave
- rdata_i  in  NumOut x RespDataWidth  response data per slave
- rrdy_o  out  NumOut  response ready per slave
- outstanding_o  out  $clog2(MaxOutstanding+1)  number of transactions awaiting a response
- idle_o  out  1  high when outstanding_o == 0

Behaviour:
- Reset (async, rst_ni low) clears:
  - FIFO read/write pointers and occupancy count to 0.
  - All outputs: gnt_o, vld_o, req_o, rrdy_o, outstanding_o = 0; rdata_o = 0; idle_o = 1.
  - In-flight responses are discarded; slaves must be reset together with this block.
- Request path (combinational):
  - full = (count == MaxOutstanding).
  - req_o[add_i] = req_i & ~full; all other req_o bits are 0.
  - data_o replicates data_i on every port.
  - gnt_o = gnt_i[add_i] & req_o[add_i]. Grants on unselected ports are ignored.
- Push:
  - A push occurs when gnt_o & (~wen_i | WriteRespOn).
  - The write entry is add_i. The write pointer wraps from MaxOutstanding-1 to 0.
  - A granted write with WriteRespOn=0 does not push and does not count.
- Response path (combinational from the FIFO head h, valid only when count > 0):
  - vld_o = rvld_i[h] & (count != 0).
  - rdata_o = rdata_i[h]; rdata_o = 0 when empty.
  - rrdy_o[h] = rdy_i & (count != 0); all other rrdy_o bits are 0.
  - rvld_i on non-head ports is stalled, never dropped or reordered.
- Pop:
  - A pop occurs on vld_o & rdy_i. The read pointer wraps from MaxOutstanding-1 to 0.
- Count update:
  - count_next = count + push - pop. A simultaneous push and pop leaves count unchanged.
  - When full, a same-cycle pop does NOT allow a new request; the block issues no request while full.
- Occupancy outputs:
  - outstanding_o = count (registered).
  - idle_o = (count == 0).
- Latency and throughput:
  - Response latency is minimal: the response is presented in the same cycle the head slave asserts rvld_i.
  - One request and one response can complete per cycle while not full.
- MaxOutstanding = 1: strictly one transaction at a time; req_o stays low until the single response pops.
- Assertions (simulation only):
  - Fatal if NumOut < 2 or MaxOutstanding < 1.
  - Error on pop when empty.
  - Error on push when full.
  - Error if vld_o & ~rdy_i is followed by a change of rdata_o while vld_o stays high.

Optional Feature:
- Macro: ADDR_DEC_RESP_FIFO_OUT_REG_EN.
- Defined: a response output register is inserted between the mux and the master.
  - The slave-side pop happens when the register is empty or is being drained (rdy_i & vld_o).
  - This gives full throughput with +1 cycle response latency.
  - vld_o, rdata_o and the register valid reset to 0.
  - A full register plus a held FIFO head counts toward outstanding_o until the master accepts it.
  - idle_o requires both FIFO and register empty.
- Undefined: the response path is combinational, as described above.

Test Plan:
- Fixed-latency reads (MaxOutstanding=4): reads to slaves 3,5,3,0 granted back-to-back, each slave answers 2 cycles later, rdy_i=1 -> vld_o on 4 consecutive cycles with rdata from 3,5,3,0 in order; outstanding_o peaks at 2.
- Out-of-order slave answers:
  - Stimulus: read slave 1 then slave 2; slave 2 raises rvld_i first, holding 0xBEEF.
  - Required: rrdy_o[2] stays 0 and vld_o stays 0 until slave 1 responds with 0xA5A5.
  - Required: 0xA5A5 then 0xBEEF delivered in that order.
- Full stall:
  - Stimulus: 4 reads granted with no responses; a 5th req_i to slave 6.
  - Required: req_o == 0 and gnt_o == 0 while full.
  - Required: after one response pops, req_o[6] rises the following cycle.
- Master back-pressure:
  - Stimulus: rdy_i=0 for 3 cycles while the head slave holds rvld_i with 0x1234.
  - Required: vld_o held with rdata_o stable at 0x1234 and no pop; pop occurs in the cycle rdy_i goes 1.
- Writes with WriteRespOn=0: 3 granted writes -> outstanding_o stays 0 and idle_o stays 1; a following read behaves normally.
- Reset mid-operation: rst_ni low with 3 outstanding -> outstanding_o = 0, idle_o = 1, vld_o = 0, req_o = 0 immediately (asynchronously).
